// File: rtl/ssd1306_spi_arbiter.sv
// Purpose: shares one byte-wide SPI master between the SSD1306 command sequencer (cmd) and the pixel streamer (pix), with burst locking.
// Latency: grant in IDLE at cycle t -> spi_wr at t+1+SETUP_CYC; spi_done at d -> ack at d+1, next grant at d+1+GAP_CYC.
// Backpressure: requesters hold req until ack/err; a timed-out byte returns err and releases any burst lock.
module ssd1306_spi_arbiter #(
  parameter int SETUP_CYC   = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       cmd_req,
  input  logic [7:0] cmd_data,
  input  logic       cmd_dc,
  input  logic       cmd_lock,
  output logic       cmd_ack,
  output logic       cmd_err,
  input  logic       pix_req,
  input  logic [7:0] pix_data,
  input  logic       pix_dc,
  input  logic       pix_lock,
  output logic       pix_ack,
  output logic       pix_err,
  output logic [7:0] spi_data,
  output logic       spi_wr,
  input  logic       spi_done,
  output logic       oled_dc,
  output logic       busy,
  output logic       owner
);

  localparam int MAX_A = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYC) ? MAX_A : TIMEOUT_CYC;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          lock_q;       // burst lock held by 'owner'
  logic          byte_lock_q;  // lock bit of the byte in flight, committed only on success
  logic          grant_cmd, grant_pix;
  logic          done_hit, tmo_hit;

  // State register.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, arbitration and strobe decode.
  always_comb begin
    state_d   = state_q;
    grant_cmd = 1'b0;
    grant_pix = 1'b0;
    done_hit  = 1'b0;
    tmo_hit   = 1'b0;
    spi_wr    = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        // A held lock excludes the other requester even if it has priority.
        if (cmd_req && (!lock_q || !owner))
          grant_cmd = 1'b1;
        else if (pix_req && (!lock_q || owner))
          grant_pix = 1'b1;
        if (grant_cmd || grant_pix)
          state_d = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = S_SEND;
      end
      S_SEND: begin
        spi_wr  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done wins over a coincident timeout expiry.
        if (spi_done) begin
          done_hit = 1'b1;
          state_d  = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end else if (cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Phase counter, captured byte, lock flag and owner response pulses.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      lock_q      <= 1'b0;
      byte_lock_q <= 1'b0;
      spi_data    <= 8'h00;
      oled_dc     <= 1'b0;
      owner       <= 1'b0;
      cmd_ack     <= 1'b0;
      cmd_err     <= 1'b0;
      pix_ack     <= 1'b0;
      pix_err     <= 1'b0;
    end else begin
      // Counter restarts on every state change, so SETUP/WAIT/GAP each count from 0.
      if (state_d != state_q || state_q == S_IDLE) cnt_q <= '0;
      else                                         cnt_q <= cnt_q + CW'(1);

      if (grant_cmd) begin
        spi_data    <= cmd_data;
        oled_dc     <= cmd_dc;
        byte_lock_q <= cmd_lock;
        owner       <= 1'b0;
      end else if (grant_pix) begin
        spi_data    <= pix_data;
        oled_dc     <= pix_dc;
        byte_lock_q <= pix_lock;
        owner       <= 1'b1;
      end

      if (done_hit)     lock_q <= byte_lock_q;
      else if (tmo_hit) lock_q <= 1'b0;

      cmd_ack <= done_hit && !owner;
      pix_ack <= done_hit &&  owner;
      cmd_err <= tmo_hit  && !owner;
      pix_err <= tmo_hit  &&  owner;
    end
  end

endmodule
